// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter.
//               UART_DW     - width of one UART byte
//               arb_state_e - IDLE / GRANT state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder. Searches req[] in
//               the order ptr+1, ptr+2, ... (modulo NUM_REQ) and returns the
//               first asserted index.
// Ports       : req - request vector
//               ptr - last served index (search starts just after it)
//               idx - selected index (0 when nothing is requesting)
//               any - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest
    // asserted request overwrites any earlier hit.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Packet-level round-robin arbiter sharing one UART write port
//               among NUM_REQ byte-stream requesters. A granted requester
//               owns the transmitter until its last byte; a stall watchdog
//               revokes the grant after TIMEOUT consecutive no-valid cycles.
// Ports       : clk, reset_n          - clock, async active-low reset
//               req_valid/data/last   - per-requester byte stream (in)
//               req_ready             - per-requester accept (out)
//               tx_full               - UART TX FIFO full (in)
//               wr_uart, w_data       - UART write strobe and byte (out)
//               grant_id, busy, abort - owner, grant active, watchdog pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 1023,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [UART_DW*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_full,
    output logic                       wr_uart,
    output logic [UART_DW-1:0]         w_data,
    output logic [IW-1:0]              grant_id,
    output logic                       busy,
    output logic                       abort
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          abort_q, abort_d;

    logic [UART_DW-1:0] data_arr [NUM_REQ];
    logic               sel_valid;
    logic               sel_last;
    logic [UART_DW-1:0] sel_data;
    logic               xfer;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign data_arr[g] = req_data[g*UART_DW +: UART_DW];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_data  = data_arr[grant_q];

    assign busy     = (state_q == GRANT);
    assign abort    = abort_q;
    assign grant_id = grant_q;
    assign xfer     = busy && sel_valid && !tx_full;
    assign wr_uart  = xfer;
    // Forced to zero outside a grant so every output is quiet in reset/idle.
    assign w_data   = busy ? sel_data : '0;

    always_comb begin
        req_ready = '0;
        if (busy && !tx_full) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (sel_last) begin
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end
                end else if (!sel_valid) begin
                    // Only a missing byte counts as a stall; a full UART
                    // with a byte waiting leaves the counter untouched.
                    if (cnt_q == CNT_LAST) begin
                        abort_d = 1'b1;
                        ptr_d   = grant_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

endmodule : uart_tx_arb
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb (NUM_REQ=4, TIMEOUT=8).
//               Per-requester byte sources feed the DUT; every pushed byte
//               is also queued as an expected (owner, byte) pair that is
//               popped and compared on each wr_uart strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic           clk       = 1'b0;
    logic           reset_n   = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic           tx_full   = 1'b0;
    logic [N-1:0]   req_ready;
    logic           wr_uart;
    logic [7:0]     w_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic           abort;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_abort = 0;

    logic [8:0] src_mem [N][32];
    int         src_wr  [N] = '{default: 0};
    int         src_rd  [N] = '{default: 0};
    exp_t       exp_q   [$];
    exp_t       e_mon;

    uart_tx_arb #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        exp_t e;
        src_mem[2'(id)][5'(src_wr[2'(id)])] = {l, d};
        src_wr[2'(id)]++;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_rd[2'(i)] < src_wr[2'(i)]) begin
                req_valid[2'(i)]          = 1'b1;
                req_data[5'(8*i) +: 8]    = src_mem[2'(i)][5'(src_rd[2'(i)])][7:0];
                req_last[2'(i)]           = src_mem[2'(i)][5'(src_rd[2'(i)])][8];
            end else begin
                req_valid[2'(i)]          = 1'b0;
                req_data[5'(8*i) +: 8]    = 8'h00;
                req_last[2'(i)]           = 1'b0;
            end
        end
    endtask

    task automatic monitor_step();
        if (abort === 1'b1) n_abort++;
        if (tx_full === 1'b1) begin
            n_vec++;
            assert (wr_uart === 1'b0) else begin
                n_err++;
                $error("FAIL wr_while_full observed=%b expected=0", wr_uart);
            end
        end
        if (wr_uart === 1'b1) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_wr observed id=%0d byte=%02h expected=none", grant_id, w_data);
            end
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                n_vec++;
                assert ({grant_id, w_data} === {e_mon.id, e_mon.data}) else begin
                    n_err++;
                    $error("FAIL sb_byte observed id=%0d byte=%02h expected id=%0d byte=%02h",
                           grant_id, w_data, e_mon.id, e_mon.data);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[2'(i)] && req_ready[2'(i)]) src_rd[2'(i)]++;
        end
    endtask

    task automatic drain(input int bound, input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   got;
        longint t_now;
        longint t_last;

        fork
            forever begin @(posedge clk); #1; drive_inputs(); end
            forever begin @(negedge clk); monitor_step(); end
        join_none

        // Contention: every requester holds a 2-byte packet from reset,
        // requester 0 has a second packet queued behind its first.
        push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1);
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_wr",    32'(wr_uart),   32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_abort", 32'(abort),     32'd0);
        chk("rst_grant", 32'(grant_id),  32'd0);
        chk("rst_wdata", 32'(w_data),    32'd0);

        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk); chk("arb_lat_idle", 32'(busy), 32'd0);
        @(negedge clk); chk("arb_lat_busy", 32'(busy), 32'd1);
        chk("cont_first_grant", 32'(grant_id), 32'd0);
        drain(80, "cont_drain");
        @(negedge clk); chk("cont_idle", 32'(busy), 32'd0);

        // Single requester 2: 41, 42, 43(last).
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
        @(negedge clk); chk("single_pre_busy", 32'(busy), 32'd0);
        @(negedge clk); chk("single_busy",  32'(busy),      32'd1);
        chk("single_grant", 32'(grant_id),  32'd2);
        chk("single_ready", 32'(req_ready), 32'b0100);
        chk("single_wr0",   32'(wr_uart),   32'd1);
        @(negedge clk); chk("single_wr1", 32'(wr_uart), 32'd1);
        @(negedge clk); chk("single_wr2", 32'(wr_uart), 32'd1);
        @(negedge clk); chk("single_release", 32'(busy), 32'd0);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: 20 full cycles mid-packet, longer than TIMEOUT.
        push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b0);
        push(0, 8'h53, 1'b0); push(0, 8'h54, 1'b1);
        repeat (2) @(negedge clk); chk("bp_wr0", 32'(wr_uart), 32'd1);
        @(negedge clk);            chk("bp_wr1", 32'(wr_uart), 32'd1);
        @(posedge clk); #1; tx_full = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_full_wr",    32'(wr_uart),   32'd0);
            chk("bp_full_ready", 32'(req_ready), 32'd0);
            chk("bp_full_abort", 32'(abort),     32'd0);
            chk("bp_full_busy",  32'(busy),      32'd1);
        end
        @(posedge clk); #1; tx_full = 1'b0;
        drain(20, "bp_drain");
        chk("bp_no_abort", 32'(n_abort), 32'd0);
        @(negedge clk); chk("bp_idle", 32'(busy), 32'd0);

        // Watchdog: requester 1 stalls after one byte, requester 3 waits.
        push(1, 8'h55, 1'b0);
        push(3, 8'h77, 1'b0); push(3, 8'h78, 1'b1);
        repeat (2) @(negedge clk);
        chk("wd_wr",    32'(wr_uart),  32'd1);
        chk("wd_grant", 32'(grant_id), 32'd1);
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("wd_stall_abort", 32'(abort), 32'd0);
            chk("wd_stall_busy",  32'(busy),  32'd1);
        end
        @(negedge clk);
        chk("wd_abort",      32'(abort), 32'd1);
        chk("wd_abort_busy", 32'(busy),  32'd0);
        @(negedge clk);
        chk("wd_next_busy",  32'(busy),     32'd1);
        chk("wd_next_grant", 32'(grant_id), 32'd3);
        chk("wd_abort_end",  32'(abort),    32'd0);
        drain(20, "wd_drain");
        @(negedge clk); chk("wd_idle", 32'(busy), 32'd0);

        // Single-byte packets alternating between requesters 0 and 1.
        push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1);
        push(0, 8'hA2, 1'b1); push(1, 8'hA3, 1'b1);
        push(0, 8'hA4, 1'b1); push(1, 8'hA5, 1'b1);
        got    = 0;
        t_last = 0;
        for (int k = 0; k < 60 && got < 6; k++) begin
            @(negedge clk);
            if (wr_uart === 1'b1) begin
                t_now = $time;
                if (got > 0) chk("sb_gap", 32'((t_now - t_last) / 10), 32'd2);
                t_last = t_now;
                got++;
            end
        end
        chk("sb_count", 32'(got), 32'd6);
        drain(10, "sb_drain");

        // Reset mid-packet: requester 2 is cut off after its 2nd byte.
        push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b0);
        push(2, 8'h64, 1'b0); push(2, 8'h65, 1'b1);
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        repeat (2) @(negedge clk);
        chk("mrst_wr0",   32'(wr_uart),  32'd1);
        chk("mrst_grant", 32'(grant_id), 32'd2);
        @(negedge clk); chk("mrst_wr1", 32'(wr_uart), 32'd1);
        @(posedge clk); #1; reset_n = 1'b0;
        #1;
        chk("mrst_wr",    32'(wr_uart),   32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < N; i++) src_rd[2'(i)] = src_wr[2'(i)];
        exp_q.delete();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b0);
        push(2, 8'h64, 1'b0); push(2, 8'h65, 1'b1);
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_first_grant", 32'(grant_id), 32'd0);
        chk("mrst_first_busy",  32'(busy),     32'd1);
        drain(40, "mrst_drain");
        @(negedge clk); chk("final_idle", 32'(busy), 32'd0);
        chk("abort_total", 32'(n_abort), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arb
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares the UART transmit path (single write port `wr_uart`/`w_data`, backpressure `tx_full`) among NUM_REQ byte-stream requesters. Once a requester is granted, it owns the transmitter until it delivers its `last` byte, so packets never interleave on the serial line. A stall watchdog reclaims the transmitter from a requester that stops supplying data mid-packet. The block sits between on-chip message sources (debug console, status reporter, echo path) and the `uart` write interface, in the `clk` domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1023: consecutive granted-but-no-valid cycles before the grant is revoked, 1..65535.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte on `req_data[8i+7:8i]`.
- `req_data` in 8*NUM_REQ: packed request bytes.
- `req_last` in NUM_REQ: byte i is the final byte of its packet.
- `req_ready` out NUM_REQ: byte i accepted this cycle (valid && ready = transfer).
- `tx_full` in 1: UART TX FIFO full.
- `wr_uart` out 1: write strobe to the UART, one byte per high cycle.
- `w_data` out 8: byte to the UART.
- `grant_id` out clog2(NUM_REQ): current owner; meaningful when `busy`=1.
- `busy` out 1: a packet grant is active.
- `abort` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GRANT. Registers: state, `grant_id`, round-robin pointer `ptr` (last served), stall counter.
- IDLE: if any `req_valid`, select the first asserted index searching ptr+1, ptr+2, … modulo NUM_REQ. Load `grant_id`, clear the stall counter, and go to GRANT. With no valid, stay in IDLE.
- GRANT: `req_ready[grant_id]` = !`tx_full`. All other `req_ready` bits are 0.
- `wr_uart` = GRANT && `req_valid[grant_id]` && !`tx_full`. `w_data` = `req_data` of `grant_id` (combinational mux). `wr_uart` is never high while `tx_full`=1.
- Transfer with `req_last[grant_id]`=1: set `ptr` to `grant_id` and go to IDLE.
- Transfer without last: clear the stall counter.
- `req_valid[grant_id]`=0: increment the stall counter. Cycles with valid=1 and `tx_full`=1 hold the counter (UART backpressure is not a stall).
- Counter reaches TIMEOUT: assert `abort` for 1 cycle, set `ptr` to `grant_id`, and go to IDLE. The partial packet is not resumed.
- Bytes a requester presents while not granted are held by that requester (`ready`=0). Nothing is dropped.
- `busy` = (state == GRANT).
- Reset values: state IDLE, `ptr` = NUM_REQ-1 (so requester 0 wins first), `grant_id` 0, counter 0. All outputs are 0 during reset.

## Timing
- Arbitration latency is one cycle. A request asserted in cycle n while IDLE gives `busy`=1 in n+1, and the first `wr_uart` is possible in n+1.
- Throughput within a packet is one byte per cycle while valid and !`tx_full`.
- Packet gap: the cycle after a last-byte transfer is IDLE. The next grant takes effect one cycle later, so there are 2 cycles between the last byte of one packet and the first byte of the next.
- `abort` is high in the cycle the state returns to IDLE. No transfer happens in that cycle.
- A `reset_n` assertion mid-packet immediately drops `wr_uart` and `busy`. The packet tail is lost, and requesters restart after reset.
- Simultaneous last-byte transfer and counter reaching TIMEOUT: the counter is cleared by the transfer, so no abort occurs.
- A single-byte packet (valid and last in the same cycle) releases the grant after that one byte.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE, GRANT), `UART_DW` = 8.
- One sub-module, `rr_pick`: combinational rotating priority encoder with inputs `req`[NUM_REQ] and `ptr` and outputs `idx` and `any`. Reusable by other arbiters.
- Total RTL is approximately 150–250 lines.

## Test plan
- Single requester: req 2 sends 0x41, 0x42, 0x43 (last on 0x43) with `tx_full`=0. Expect `busy` high 1 cycle after the request, then 3 consecutive `wr_uart` with `w_data` 41, 42, 43, then `busy`=0.
- Contention: all 4 requesters hold 2-byte packets from reset. Expect serving order 0, 1, 2, 3, 0, with no interleaving of bytes inside any packet.
- Backpressure: `tx_full`=1 for 20 cycles mid-packet with `TIMEOUT`=8. Expect `wr_uart`=0 and `req_ready`=0 throughout, no `abort`, and the packet completes after `tx_full` falls.
- Watchdog: with `TIMEOUT`=8, requester 1 sends 1 byte (not last) then drops valid. Expect `abort` 8 cycles later, then requester 3 (pending) granted next.
- Reset mid-packet: assert `reset_n`=0 after the 2nd of 5 bytes. Expect `wr_uart`, `busy` and `req_ready` at 0 immediately, and after release requester 0 wins first.
- Single-byte packets back-to-back from req 0 and req 1: expect alternating grants and a 2-cycle gap between the `wr_uart` strobes.
